msdap_serial_tx: RTL
====================

# msdap_serial_tx

Host-side serial transmitter for the MSDAP audio input port. It accepts parallel 16-bit left/right sample pairs over a valid/ready handshake and generates the Dclk bit clock. It emits the Frame sync and shifts both words MSB-first on InputL/InputR, which is the format the chip's S2P front end deserializes. It runs entirely on Sclk, honours the chip's InReady flow control, and is used by the top-level bench and the FPGA board harness to drive MSDAP.

## Interface
Parameters:
- CLK_DIV, 35, Sclk cycles per Dclk period (26.88 MHz / 768 kHz); legal range 4..255.
- WORD_W, 16, bits per channel word; fixed at 16 for MSDAP.

Ports:
- Sclk  in  1  system clock; the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- run  in  1  transmit enable; sampled at frame boundaries only.
- in_valid  in  1  sample pair on in_l/in_r is valid.
- in_ready  out  1  holding register empty; a transfer occurs when in_valid && in_ready.
- in_l  in  16  left sample word.
- in_r  in  16  right sample word.
- InReady  in  1  MSDAP ready flag; sampled at frame boundaries only.
- Dclk  out  1  generated data clock, free-running after reset.
- Frame  out  1  high during the MSB bit period of each word.
- InputL  out  1  left serial data, MSB first.
- InputR  out  1  right serial data, MSB first.
- underrun  out  1  one-Sclk pulse when a frame starts with no buffered data.
- busy  out  1  high while in SEND.

## Operation
- Divider: cnt runs 0..CLK_DIV-1 and wraps. tick = (cnt == CLK_DIV-1).
- Dclk: registered. It is set on the edge that ends a tick cycle and cleared on the edge that ends cycle cnt == CLK_DIV/2-1 (integer division). High for CLK_DIV/2 Sclk cycles, low for the remainder.
- Data updates only at tick edges, coincident with the Dclk rise. MSDAP samples on the Dclk fall, which lands mid-bit.
- Holding register: hold_l, hold_r, hold_valid. in_ready = !hold_valid.
  - An accept sets hold_valid on the next edge.
  - A frame load clears hold_valid.
  - An accept cannot coincide with a load, because in_ready is low whenever hold_valid is set.
- Shift registers: sh_l and sh_r (16 bits each), plus bit_idx counting 15..0.
  - InputL = sh_l[15] and InputR = sh_r[15] (both registered).
  - Frame = (bit_idx == 15) while in SEND.
- FSM states: IDLE and SEND.
  - IDLE: Frame, InputL, InputR and busy are 0. At a tick with run && InReady, go to SEND with bit_idx = 15 and perform a load.
  - SEND: at each tick with bit_idx > 0, shift sh_l/sh_r left by one and decrement bit_idx.
  - SEND, at the tick with bit_idx == 0: if run && InReady, perform a load with bit_idx = 15 and no gap bit. Otherwise go to IDLE and drive the outputs low.
- Load:
  - If hold_valid: sh_l/sh_r get hold_l/hold_r and hold_valid is cleared.
  - Otherwise: sh_l/sh_r get 0, which MSDAP treats as silence, and underrun pulses for one Sclk cycle (the load edge).
- Deasserting run or InReady mid-frame has no effect until the frame boundary. The current word always completes all 16 bits.
- Reset (synchronous, any state, including mid-frame):
  - cnt = 0, state = IDLE, hold_valid = 0, sh = 0, bit_idx = 15.
  - Output reset values: Dclk 0, Frame 0, InputL 0, InputR 0, underrun 0, busy 0, in_ready 1.
  - A partially sent word is discarded and not retransmitted.

## Timing
- One word period = 16 × CLK_DIV Sclk cycles (560 at default). Frames are back-to-back while data keeps flowing.
- After reset deasserts, the first tick occurs at cycle CLK_DIV-1. The first Dclk rise is visible at cycle CLK_DIV.
- Start latency: from the first tick with run && InReady && hold_valid, the MSB and Frame are visible on the next cycle.
- in_ready rises the cycle after a load edge. It stays low from the accept edge until that pair is loaded.
- Throughput: the holding register plus the shift register give double buffering. One accept per word period sustains the stream with no underrun.
- underrun and busy change only on tick edges. underrun is never high for two consecutive Sclk cycles.

## Test plan
- Reset, then CLK_DIV=35, run=1, InReady=1, one pair L=0xA5C3, R=0x0F0F → Frame high for the first bit period; InputL bits 1010010111000011; InputR bits 0000111100001111; Dclk high 17 cycles and low 18; after the word, a zero frame with an underrun pulse.
- Stream 4 pairs (0x0001, 0x8000, 0xFFFF, 0x1234), each presented as soon as in_ready rises → 4 contiguous frames spaced exactly 560 cycles apart, no underrun, busy high throughout.
- run=1, InReady=1, no data → a zero word every 560 cycles with one underrun pulse per frame; in_ready stays 1.
- InReady dropped at bit 8 of word 0x7FFE → the remaining 8 bits complete; at the boundary the block enters IDLE with outputs 0; raising InReady restarts at the next tick with the buffered word.
- Reset asserted at bit 5 of a frame → the next cycle shows all outputs at reset values and in_ready=1; the buffered pair is dropped and Dclk restarts its phase from cnt=0.
- in_valid held high with a fixed pair while the holding register is full → exactly one accept per load, in_ready low between loads, no duplicated or lost words across 3 frames.

Source files
------------

// File: rtl/msdap_serial_tx.sv
// msdap_serial_tx: host-side serial transmitter feeding MSDAP's S2P input port.
//   Sclk_i       system clock (only clock)
//   Reset_i      synchronous active-high reset
//   run_i        transmit enable, sampled at frame boundaries
//   in_valid_i   sample pair on in_l_i/in_r_i is valid
//   in_ready_o   holding register empty
//   in_l_i       left sample word
//   in_r_i       right sample word
//   InReady_i    MSDAP ready flag, sampled at frame boundaries
//   Dclk_o       generated data clock, CLK_DIV/2 Sclk cycles high
//   Frame_o      high during the MSB bit period of each word
//   InputL_o     left serial data, MSB first
//   InputR_o     right serial data, MSB first
//   underrun_o   one-cycle pulse when a frame loads with no buffered data
//   busy_o       high while sending
module msdap_serial_tx #(
    parameter int CLK_DIV = 35,
    parameter int WORD_W  = 16
) (
    input  logic              Sclk_i,
    input  logic              Reset_i,
    input  logic              run_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_l_i,
    input  logic [WORD_W-1:0] in_r_i,
    input  logic              InReady_i,
    output logic              Dclk_o,
    output logic              Frame_o,
    output logic              InputL_o,
    output logic              InputR_o,
    output logic              underrun_o,
    output logic              busy_o
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [7:0] TOP = 8'(CLK_DIV - 1);
    localparam logic [7:0] HALF = 8'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] MSB_IDX = BW'(WORD_W - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              dclk_q, dclk_d;
    logic [WORD_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic              underrun_q, underrun_d;
    logic              tick, load;

    always_comb begin
        tick         = cnt_q == TOP;
        cnt_d        = tick ? '0 : cnt_q + 8'd1;
        dclk_d       = tick ? 1'b1 : (cnt_q == HALF ? 1'b0 : dclk_q);
        // a new word may only start at a tick that is also a word boundary
        load         = tick && run_i && InReady_i && (state_q == IDLE || bit_idx_q == '0);
        state_d      = state_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        sh_l_d       = sh_l_q;
        sh_r_d       = sh_r_q;
        bit_idx_d    = bit_idx_q;
        underrun_d   = 1'b0;
        if (load) begin
            state_d      = SEND;
            bit_idx_d    = MSB_IDX;
            sh_l_d       = hold_valid_q ? hold_l_q : '0;
            sh_r_d       = hold_valid_q ? hold_r_q : '0;
            hold_valid_d = 1'b0;
            underrun_d   = !hold_valid_q;
        end else if (tick && state_q == SEND) begin
            if (bit_idx_q != '0) begin
                sh_l_d    = {sh_l_q[WORD_W-2:0], 1'b0};
                sh_r_d    = {sh_r_q[WORD_W-2:0], 1'b0};
                bit_idx_d = bit_idx_q - 1'b1;
            end else begin
                // clearing the shifters is what drives the data lines low in IDLE
                state_d   = IDLE;
                sh_l_d    = '0;
                sh_r_d    = '0;
                bit_idx_d = MSB_IDX;
            end
        end
        // an accept only happens with the holding register empty, so it never races a load's clear
        if (in_valid_i && !hold_valid_q) begin
            hold_l_d     = in_l_i;
            hold_r_d     = in_r_i;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Sclk_i) begin
        if (Reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dclk_q       <= 1'b0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            sh_l_q       <= '0;
            sh_r_q       <= '0;
            bit_idx_q    <= MSB_IDX;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dclk_q       <= dclk_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            sh_l_q       <= sh_l_d;
            sh_r_q       <= sh_r_d;
            bit_idx_q    <= bit_idx_d;
            underrun_q   <= underrun_d;
        end
    end

    assign in_ready_o = !hold_valid_q;
    assign Dclk_o     = dclk_q;
    assign Frame_o    = state_q == SEND && bit_idx_q == MSB_IDX;
    assign InputL_o   = sh_l_q[WORD_W-1];
    assign InputR_o   = sh_r_q[WORD_W-1];
    assign underrun_o = underrun_q;
    assign busy_o     = state_q == SEND;
endmodule
